pipeline_hazard_scoreboard: RTL and testbench
=============================================

// Module: pipeline_hazard_scoreboard
// PURPOSE
//  Parametrised hazard/forwarding controller for the 5-stage RV32 pipeline. It generates the stall,
//  flush and forward selects. It adds a scoreboard for one non-pipelined multi-cycle unit (MUL/DIV).
//  The unit is issued from E and writes back through a dedicated regfile port after MUL_LAT cycles.
//  Sits beside the D/E/M/W pipeline registers; replaces the purely combinational hazard unit.
// PARAMETERS
//  REG_AW   5   register address width (2**REG_AW architectural regs; x0 hard-zero)
//  MUL_LAT  4   cycles from issue to result ready; legal range 1..15
//  CNT_W    32  width of perf counters (only with PIPE_PERF_CNT_EN)
// PORTS
//  clk          in   1       clock, rising edge
//  reset        in   1       asynchronous, active-low (0 = reset)
//  Rs1D,Rs2D,RdD in  REG_AW  D-stage source/dest addresses
//  MulD         in   1       D-stage instr is a multi-cycle op
//  Rs1E,Rs2E,RdE in  REG_AW  E-stage addresses
//  RegWriteE    in   1       E-stage writes regfile
//  ResultSrcE   in   2       01 = load in E
//  MulStartE    in   1       multi-cycle op in E (issue this cycle)
//  RdM,RdW      in   REG_AW  M/W dest; RegWriteM,RegWriteW in 1 each
//  PCSrcE       in   1       taken branch/jump resolved in E
//  StallF,StallD out 1       hold PC / D register
//  FlushD,FlushE out 1       bubble D / E register
//  ForwardAE,ForwardBE out 2 00 regfile, 01 ResultW, 10 ResultM
//  MulBusy      out  1       scoreboard state != IDLE
//  MulWbEn      out  1       one-cycle regfile write strobe for unit result
//  MulWbRd      out  REG_AW  destination of unit result
// BEHAVIOUR
//  Reset: all outputs 0; FSM IDLE; count 0; pending rd 0. Reset mid-op abandons the op, no writeback.
//  Forwarding (comb): per source, M match beats W match; needs RegWrite and Rd != 0; else 00.
//  Load-use: RegWriteE & ResultSrcE==01 & RdE!=0 & RdE in {Rs1D,Rs2D} -> StallF,StallD,FlushE.
//  Scoreboard FSM:
//   IDLE: on MulStartE, latch RdE into pend_rd, set count=MUL_LAT-1, go BUSY (MUL_LAT=1: go WB).
//   BUSY: count decrements each cycle; at count==0 go WB.
//   WB: MulWbEn=1 iff RegWriteW==0 (W stage owns the port); MulWbRd=pend_rd.
//       After a strobe, go IDLE next cycle. Otherwise stay in WB (retry).
//  Scoreboard stalls (StallF,StallD,FlushE):
//   - MulD & (state!=IDLE | MulStartE): structural, one unit.
//   - state!=IDLE & pend_rd!=0 & pend_rd in {Rs1D,Rs2D,RdD}: RAW/WAW.
//   - Released the cycle after MulWbEn; no bypass of unit result.
//  Redirect: PCSrcE -> FlushD=1, FlushE=1, StallF=0, StallD=0; overrides every stall above.
//  An op already issued (FSM!=IDLE) is never cancelled by a flush.
//  MulStartE while FSM!=IDLE cannot occur by construction. If seen, ignore it (assertion in sim).
//  pend_rd==0: unit runs but MulWbEn stays 0 and no dependency stalls are raised.
// CONFIGURATION
//  PIPE_PERF_CNT_EN defined: adds outputs stall_cnt, flush_cnt, mul_wait_cnt [CNT_W-1:0].
//   - Counts cycles with StallD, with FlushD, and with WB-retry.
//   - Saturating; cleared by reset.
//  Undefined: ports and counters absent; no other change.
// TESTING
//  1 Fwd: RdM=5 RegWriteM=1, RdW=5 RegWriteW=1, Rs1E=5 -> ForwardAE=10; RdM=0 -> ForwardAE=00.
//  2 Load-use: lw x6 in E, Rs2D=6 -> StallF=StallD=FlushE=1 for 1 cycle; then ForwardBE=01.
//  3 Mul MUL_LAT=4: MulStartE RdE=7 at T0 -> MulWbEn=1, MulWbRd=7 at T4.
//    Rs1D=7 stalled T1..T4; released T5.
//  4 WB conflict: RegWriteW=1 at T4,T5 -> MulWbEn at T6 only; mul_wait_cnt=2 if enabled.
//  5 Back-to-back MulD while MulStartE -> stalled until FSM IDLE.
//    PCSrcE=1 during stall -> flush, no stall; pending op still writes back.
//  6 reset=0 during BUSY -> MulBusy=0, no MulWbEn; all outputs 0 asynchronously.

Source files
------------

// File: rtl/pipeline_hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_scoreboard
//
// Hazard and forwarding controller for the 5-stage RV32 pipeline (F/D/E/M/W).
// It also tracks one non-pipelined multi-cycle unit (MUL/DIV). The unit is
// issued from E and writes its result back through a dedicated register-file
// port MUL_LAT cycles after issue.
//
// Parameters
//   REG_AW   register address width (x0 is hard-wired zero)
//   MUL_LAT  cycles from issue to result ready, legal range 1..15
//   CNT_W    width of the optional performance counters
//
// Optional feature macro
//   PIPE_PERF_CNT_EN  adds the saturating counters stall_cnt, flush_cnt and
//                     mul_wait_cnt. They count cycles with StallD, cycles with
//                     FlushD, and cycles the unit waits in WB for the port.
//
// Ports
//   clk, reset                   rising-edge clock, async active-low reset
//   Rs1D, Rs2D, RdD, MulD        D-stage operands, destination, multi-cycle flag
//   Rs1E, Rs2E, RdE              E-stage operands and destination
//   RegWriteE, ResultSrcE        E-stage write enable and result source (01 = load)
//   MulStartE                    issue of the multi-cycle op sitting in E
//   RdM, RegWriteM               M-stage destination and write enable
//   RdW, RegWriteW               W-stage destination and write enable
//   PCSrcE                       taken branch/jump resolved in E
//   StallF, StallD               hold PC / D register
//   FlushD, FlushE               bubble D / E register
//   ForwardAE, ForwardBE         operand select: 00 regfile, 01 ResultW, 10 ResultM
//   MulBusy                      unit has an op in flight
//   MulWbEn, MulWbRd             one-cycle write strobe and destination of unit result
// -----------------------------------------------------------------------------
module pipeline_hazard_scoreboard #(
    parameter int REG_AW  = 5,
    parameter int MUL_LAT = 4,
    parameter int CNT_W   = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_AW-1:0] Rs1D,
    input  logic [REG_AW-1:0] Rs2D,
    input  logic [REG_AW-1:0] RdD,
    input  logic              MulD,
    input  logic [REG_AW-1:0] Rs1E,
    input  logic [REG_AW-1:0] Rs2E,
    input  logic [REG_AW-1:0] RdE,
    input  logic              RegWriteE,
    input  logic [1:0]        ResultSrcE,
    input  logic              MulStartE,
    input  logic [REG_AW-1:0] RdM,
    input  logic              RegWriteM,
    input  logic [REG_AW-1:0] RdW,
    input  logic              RegWriteW,
    input  logic              PCSrcE,
    output logic              StallF,
    output logic              StallD,
    output logic              FlushD,
    output logic              FlushE,
    output logic [1:0]        ForwardAE,
    output logic [1:0]        ForwardBE,
    output logic              MulBusy,
    output logic              MulWbEn,
    output logic [REG_AW-1:0] MulWbRd
`ifdef PIPE_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt,
    output logic [CNT_W-1:0]  mul_wait_cnt
`endif
);

    // MUL_LAT must fit the 4-bit countdown; reject illegal configurations
    // at elaboration rather than letting the count wrap.
    if (MUL_LAT < 1 || MUL_LAT > 15 || CNT_W < 1) begin : gBadParams
        $error("pipeline_hazard_scoreboard: MUL_LAT must be 1..15 and CNT_W >= 1");
    end

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        WB   = 2'b10
    } mulState_t;

    localparam logic [3:0] LAT_M1 = 4'(MUL_LAT - 1);

    mulState_t         state, stateNext;
    logic [3:0]        count, countNext;
    logic [REG_AW-1:0] pendRd, pendRdNext;

    logic busy;
    logic wbGrant;
    logic wbStrobe;
    logic loadUse;
    logic mulStruct;
    logic mulDep;
    logic stallReq;

    // -------------------------------------------------------------------------
    // Scoreboard FSM: state register
    // -------------------------------------------------------------------------
    // NOTE: state is updated with non-blocking assignments so every register
    // samples the values from before the edge, whatever the statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            count  <= '0;
            pendRd <= '0;
        end else begin
            state  <= stateNext;
            count  <= countNext;
            pendRd <= pendRdNext;
        end
    end

    // -------------------------------------------------------------------------
    // Scoreboard FSM: next-state logic
    // -------------------------------------------------------------------------
    // NOTE: every variable gets a default at the top of the block; a path that
    // left one unassigned would infer a latch.
    always_comb begin
        stateNext  = state;
        countNext  = count;
        pendRdNext = pendRd;
        unique case (state)
            IDLE: begin
                // An issue seen while busy is impossible by construction and
                // is simply not accepted here (see the assertion below).
                if (MulStartE) begin
                    pendRdNext = RdE;
                    countNext  = LAT_M1;
                    stateNext  = (MUL_LAT == 1) ? WB : BUSY;
                end
            end
            BUSY: begin
                // The count reaches zero on the same edge the FSM enters WB,
                // so the strobe lands exactly MUL_LAT cycles after issue.
                countNext = count - 4'd1;
                if (count == 4'd1) begin
                    stateNext = WB;
                end
            end
            WB: begin
                // The W stage owns the shared write port. Retry until the
                // port is free, then release.
                if (!RegWriteW) begin
                    stateNext = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Scoreboard FSM: outputs
    // -------------------------------------------------------------------------
    always_comb begin
        busy     = (state != IDLE);
        wbGrant  = (state == WB) && !RegWriteW;
        // A result destined for x0 completes silently.
        wbStrobe = wbGrant && (pendRd != '0);
        MulBusy  = busy;
        MulWbEn  = wbStrobe;
        MulWbRd  = (state == WB) ? pendRd : '0;
    end

    // -------------------------------------------------------------------------
    // Hazard detection
    // -------------------------------------------------------------------------
    always_comb begin
        loadUse   = RegWriteE && (ResultSrcE == 2'b01) && (RdE != '0) &&
                    ((RdE == Rs1D) || (RdE == Rs2D));
        // Only one unit exists, so a second multi-cycle op must wait in D.
        mulStruct = MulD && (busy || MulStartE);
        // The unit result is never bypassed. Readers and writers of the
        // pending register wait until the cycle after the writeback.
        mulDep    = busy && (pendRd != '0) &&
                    ((pendRd == Rs1D) || (pendRd == Rs2D) || (pendRd == RdD));
        stallReq  = loadUse || mulStruct || mulDep;
    end

    function automatic logic [1:0] fwdSel(
        input logic [REG_AW-1:0] src,
        input logic [REG_AW-1:0] rdM,
        input logic              regWriteM,
        input logic [REG_AW-1:0] rdW,
        input logic              regWriteW
    );
        logic [1:0] sel;
        sel = 2'b00;
        // M holds the younger producer, so it takes priority over W.
        if (regWriteM && (rdM != '0) && (rdM == src)) begin
            sel = 2'b10;
        end else if (regWriteW && (rdW != '0) && (rdW == src)) begin
            sel = 2'b01;
        end
        return sel;
    endfunction

    // The combinational outputs are also forced to 0 while reset is asserted,
    // so the whole output set clears asynchronously. The registered outputs
    // above already do so through the state register.
    always_comb begin
        StallF    = 1'b0;
        StallD    = 1'b0;
        FlushD    = 1'b0;
        FlushE    = 1'b0;
        ForwardAE = 2'b00;
        ForwardBE = 2'b00;
        if (reset) begin
            ForwardAE = fwdSel(Rs1E, RdM, RegWriteM, RdW, RegWriteW);
            ForwardBE = fwdSel(Rs2E, RdM, RegWriteM, RdW, RegWriteW);
            if (PCSrcE) begin
                // A redirect squashes the younger instructions, so stalling
                // them is pointless. An op already in the unit is unaffected.
                FlushD = 1'b1;
                FlushE = 1'b1;
            end else if (stallReq) begin
                StallF = 1'b1;
                StallD = 1'b1;
                FlushE = 1'b1;
            end
        end
    end

`ifdef PIPE_PERF_CNT_EN
    // -------------------------------------------------------------------------
    // Performance counters (saturating)
    // -------------------------------------------------------------------------
    logic wbRetry;
    assign wbRetry = (state == WB) && RegWriteW;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt    <= '0;
            flush_cnt    <= '0;
            mul_wait_cnt <= '0;
        end else begin
            if (StallD && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (FlushD && (flush_cnt != '1)) begin
                flush_cnt <= flush_cnt + CNT_W'(1);
            end
            if (wbRetry && (mul_wait_cnt != '1)) begin
                mul_wait_cnt <= mul_wait_cnt + CNT_W'(1);
            end
        end
    end
`endif

    // A second issue while an op is in flight means the surrounding pipeline
    // broke the structural stall.
    assert property (@(posedge clk) disable iff (!reset) !(MulStartE && busy));

endmodule

// File: tb/tb_pipeline_hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// Bench for pipeline_hazard_scoreboard. A behavioural model tracks the unit as
// "op issued N cycles ago" and derives every output from the hazard rules. It
// is compared against the DUT on each falling edge. Directed scenarios add
// hand-computed literal checks that pin the model.
// -----------------------------------------------------------------------------
module tb_pipeline_hazard_scoreboard;

    localparam int REG_AW  = 5;
    localparam int MUL_LAT = 4;
    localparam int CNT_W   = 32;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic [REG_AW-1:0] Rs1D = '0, Rs2D = '0, RdD = '0;
    logic              MulD = 1'b0;
    logic [REG_AW-1:0] Rs1E = '0, Rs2E = '0, RdE = '0;
    logic              RegWriteE = 1'b0;
    logic [1:0]        ResultSrcE = 2'b00;
    logic              MulStartE = 1'b0;
    logic [REG_AW-1:0] RdM = '0, RdW = '0;
    logic              RegWriteM = 1'b0, RegWriteW = 1'b0;
    logic              PCSrcE = 1'b0;

    logic              StallF, StallD, FlushD, FlushE;
    logic [1:0]        ForwardAE, ForwardBE;
    logic              MulBusy, MulWbEn;
    logic [REG_AW-1:0] MulWbRd;
`ifdef PIPE_PERF_CNT_EN
    logic [CNT_W-1:0]  stall_cnt, flush_cnt, mul_wait_cnt;
`endif

    always #5 clk = ~clk;

    pipeline_hazard_scoreboard #(
        .REG_AW (REG_AW),
        .MUL_LAT(MUL_LAT),
        .CNT_W  (CNT_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .Rs1D      (Rs1D),
        .Rs2D      (Rs2D),
        .RdD       (RdD),
        .MulD      (MulD),
        .Rs1E      (Rs1E),
        .Rs2E      (Rs2E),
        .RdE       (RdE),
        .RegWriteE (RegWriteE),
        .ResultSrcE(ResultSrcE),
        .MulStartE (MulStartE),
        .RdM       (RdM),
        .RegWriteM (RegWriteM),
        .RdW       (RdW),
        .RegWriteW (RegWriteW),
        .PCSrcE    (PCSrcE),
        .StallF    (StallF),
        .StallD    (StallD),
        .FlushD    (FlushD),
        .FlushE    (FlushE),
        .ForwardAE (ForwardAE),
        .ForwardBE (ForwardBE),
        .MulBusy   (MulBusy),
        .MulWbEn   (MulWbEn),
        .MulWbRd   (MulWbRd)
`ifdef PIPE_PERF_CNT_EN
        ,
        .stall_cnt   (stall_cnt),
        .flush_cnt   (flush_cnt),
        .mul_wait_cnt(mul_wait_cnt)
`endif
    );

    // -------------------------------------------------------------------------
    // Check bookkeeping
    // -------------------------------------------------------------------------
    int nChecks = 0;
    int nErrors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nErrors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // -------------------------------------------------------------------------
    // Behavioural model
    // -------------------------------------------------------------------------
    bit                opActive = 1'b0;   // an op is in the unit
    int                opAge = 0;         // cycles since issue
    logic [REG_AW-1:0] opRd = '0;
    int                stallCycles = 0, flushCycles = 0, waitCycles = 0;

    typedef struct packed {
        logic [1:0]        fa;
        logic [1:0]        fb;
        logic              stallF;
        logic              stallD;
        logic              flushD;
        logic              flushE;
        logic              busy;
        logic              wbEn;
        logic [REG_AW-1:0] wbRd;
    } exp_t;

    // Source of the newest value of register src as seen from E.
    function automatic logic [1:0] newest(input logic [REG_AW-1:0] src);
        if (src == 0) return 2'b00;
        if (RegWriteM && RdM == src) return 2'b10;
        if (RegWriteW && RdW == src) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic hazardNow();
        logic lu, st, dep;
        lu  = RegWriteE && ResultSrcE == 2'b01 && RdE != 0 && (RdE == Rs1D || RdE == Rs2D);
        st  = MulD && (opActive || MulStartE);
        dep = opActive && opRd != 0 && (opRd == Rs1D || opRd == Rs2D || opRd == RdD);
        return lu || st || dep;
    endfunction

    function automatic exp_t model();
        exp_t e;
        e = '0;
        if (!reset) return e;
        e.fa   = newest(Rs1E);
        e.fb   = newest(Rs2E);
        e.busy = opActive;
        e.wbEn = opActive && opAge >= MUL_LAT && !RegWriteW && opRd != 0;
        e.wbRd = opRd;
        if (PCSrcE) begin
            e.flushD = 1'b1;
            e.flushE = 1'b1;
        end else if (hazardNow()) begin
            e.stallF = 1'b1;
            e.stallD = 1'b1;
            e.flushE = 1'b1;
        end
        return e;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            opActive    <= 1'b0;
            opAge       <= 0;
            opRd        <= '0;
            stallCycles <= 0;
            flushCycles <= 0;
            waitCycles  <= 0;
        end else begin
            if (!PCSrcE && hazardNow()) stallCycles <= stallCycles + 1;
            if (PCSrcE) flushCycles <= flushCycles + 1;
            if (opActive) begin
                if (opAge >= MUL_LAT) begin
                    if (RegWriteW) waitCycles <= waitCycles + 1;
                    else           opActive   <= 1'b0;
                end
                opAge <= opAge + 1;
            end else if (MulStartE) begin
                opActive <= 1'b1;
                opAge    <= 1;
                opRd     <= RdE;
            end
        end
    end

    exp_t expNow;
    always_comb expNow = model();

    // Per-cycle comparison, away from the active edge.
    always @(negedge clk) begin
        check("cyc_ForwardAE", ForwardAE, expNow.fa);
        check("cyc_ForwardBE", ForwardBE, expNow.fb);
        check("cyc_StallF", StallF, expNow.stallF);
        check("cyc_StallD", StallD, expNow.stallD);
        check("cyc_FlushD", FlushD, expNow.flushD);
        check("cyc_FlushE", FlushE, expNow.flushE);
        check("cyc_MulBusy", MulBusy, expNow.busy);
        check("cyc_MulWbEn", MulWbEn, expNow.wbEn);
        if (expNow.wbEn) check("cyc_MulWbRd", MulWbRd, expNow.wbRd);
`ifdef PIPE_PERF_CNT_EN
        check("cyc_stall_cnt", stall_cnt, stallCycles);
        check("cyc_flush_cnt", flush_cnt, flushCycles);
        check("cyc_mul_wait_cnt", mul_wait_cnt, waitCycles);
`endif
    end

    // -------------------------------------------------------------------------
    // Stimulus helpers
    // -------------------------------------------------------------------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        Rs1D = '0; Rs2D = '0; RdD = '0; MulD = 1'b0;
        Rs1E = '0; Rs2E = '0; RdE = '0;
        RegWriteE = 1'b0; ResultSrcE = 2'b00; MulStartE = 1'b0;
        RdM = '0; RegWriteM = 1'b0; RdW = '0; RegWriteW = 1'b0;
        PCSrcE = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // -------------------------------------------------------------------------
    // Directed scenarios
    // -------------------------------------------------------------------------
    initial begin
        // Reset with active-looking inputs: outputs must stay 0.
        RdM = 5; RegWriteM = 1'b1; Rs1E = 5; PCSrcE = 1'b1; Rs2D = 3;
        #2;
        check("rst_ForwardAE", ForwardAE, 0);
        check("rst_FlushD", FlushD, 0);
        check("rst_MulBusy", MulBusy, 0);
        cyc(); cyc();
        clr();
        reset = 1'b1;

        // Forwarding: M beats W, x0 never forwarded.
        cyc();
        RdM = 5; RegWriteM = 1'b1; RdW = 5; RegWriteW = 1'b1; Rs1E = 5; Rs2E = 5;
        #2;
        check("fwd_m_over_w", ForwardAE, 2'b10);
        cyc();
        RdM = 0;
        #2;
        check("fwd_w_when_m_x0", ForwardAE, 2'b01);
        cyc();
        RdW = 0; Rs1E = 0; Rs2E = 9; RdM = 9; RegWriteM = 1'b0;
        #2;
        check("fwd_x0_none", ForwardAE, 2'b00);
        check("fwd_no_regwrite", ForwardBE, 2'b00);

        // Load-use: lw x6 in E, consumer reads x6 as rs2.
        cyc(); clr();
        RegWriteE = 1'b1; ResultSrcE = 2'b01; RdE = 6; Rs2D = 6;
        #2;
        check("lu_StallF", StallF, 1);
        check("lu_FlushE", FlushE, 1);
        cyc();
        RegWriteE = 1'b0; ResultSrcE = 2'b00; RdE = 0; RdM = 6; RegWriteM = 1'b1;
        #2;
        check("lu_released", StallD, 0);
        cyc();
        RdM = 0; RegWriteM = 1'b0; RdW = 6; RegWriteW = 1'b1; Rs2E = 6; Rs2D = 0;
        #2;
        check("lu_fwd_w", ForwardBE, 2'b01);
        cyc(); clr();
        RegWriteE = 1'b1; ResultSrcE = 2'b10; RdE = 6; Rs1D = 6;
        #2;
        check("lu_not_load", StallD, 0);

        // Multi-cycle op to x7, reader of x7 in D.
        cyc(); clr();
        MulStartE = 1'b1; RdE = 7; RegWriteE = 1'b1;              // T0
        #2;
        check("mul_T0_busy", MulBusy, 0);
        cyc(); clr(); Rs1D = 7;                                   // T1
        #2;
        check("mul_T1_busy", MulBusy, 1);
        check("mul_T1_stall", StallD, 1);
        cyc(); Rs1D = 0; RdD = 7;                                 // T2 (WAW)
        #2;
        check("mul_T2_waw", StallF, 1);
        cyc(); RdD = 0; Rs2D = 7;                                 // T3
        #2;
        check("mul_T3_wben", MulWbEn, 0);
        cyc(); Rs2D = 0; Rs1D = 7;                                // T4
        #2;
        check("mul_T4_wben", MulWbEn, 1);
        check("mul_T4_wbrd", MulWbRd, 7);
        check("mul_T4_stall", StallD, 1);
        cyc();                                                    // T5
        #2;
        check("mul_T5_release", StallD, 0);
        check("mul_T5_idle", MulBusy, 0);

        // Write-port conflict in WB.
        cyc(); clr();
        MulStartE = 1'b1; RdE = 9;                                // T0
        cyc(); clr();                                             // T1
        cyc(); cyc();                                             // T2, T3
        cyc(); RegWriteW = 1'b1; RdW = 3;                         // T4
        #2;
        check("wbc_T4_wben", MulWbEn, 0);
        cyc();                                                    // T5
        #2;
        check("wbc_T5_wben", MulWbEn, 0);
        check("wbc_T5_busy", MulBusy, 1);
        cyc(); RegWriteW = 1'b0; RdW = 0;                         // T6
        #2;
        check("wbc_T6_wben", MulWbEn, 1);
        check("wbc_T6_wbrd", MulWbRd, 9);
`ifdef PIPE_PERF_CNT_EN
        check("wbc_wait_cnt", mul_wait_cnt, 2);
`endif
        cyc();                                                    // T7
        #2;
        check("wbc_T7_idle", MulBusy, 0);

        // Back-to-back multi-cycle ops with a redirect in the middle.
        cyc(); clr();
        MulStartE = 1'b1; RdE = 8; MulD = 1'b1; Rs1D = 1; Rs2D = 2; RdD = 10;   // T0
        #2;
        check("b2b_T0_struct", StallD, 1);
        cyc(); MulStartE = 1'b0; RdE = 0;                         // T1
        #2;
        check("b2b_T1_struct", StallF, 1);
        cyc(); PCSrcE = 1'b1;                                     // T2
        #2;
        check("b2b_T2_flushD", FlushD, 1);
        check("b2b_T2_nostall", StallD, 0);
        cyc(); PCSrcE = 1'b0;                                     // T3
        #2;
        check("b2b_T3_stall", StallD, 1);
        cyc();                                                    // T4
        #2;
        check("b2b_T4_wben", MulWbEn, 1);
        check("b2b_T4_wbrd", MulWbRd, 8);
        cyc();                                                    // T5
        #2;
        check("b2b_T5_release", StallD, 0);

        // Op to x0: runs to completion silently, raises no dependency stall.
        cyc(); clr();
        MulStartE = 1'b1; RdE = 0;                                // T0
        cyc(); clr();                                             // T1
        #2;
        check("x0_T1_busy", MulBusy, 1);
        check("x0_T1_nostall", StallD, 0);
        cyc(); cyc(); cyc();                                      // T4
        #2;
        check("x0_T4_wben", MulWbEn, 0);
        cyc();                                                    // T5
        #2;
        check("x0_T5_idle", MulBusy, 0);

        // Reset during BUSY abandons the op.
        cyc(); clr();
        MulStartE = 1'b1; RdE = 12;                               // T0
        cyc(); clr(); Rs1D = 12; Rs1E = 5; RdM = 5; RegWriteM = 1'b1;   // T1
        cyc();                                                    // T2
        #2;
        check("rmid_busy_before", MulBusy, 1);
        reset = 1'b0;
        #1;
        check("rmid_busy", MulBusy, 0);
        check("rmid_stall", StallD, 0);
        check("rmid_fwd", ForwardAE, 0);
        check("rmid_wben", MulWbEn, 0);
`ifdef PIPE_PERF_CNT_EN
        check("rmid_stall_cnt", stall_cnt, 0);
`endif
        cyc(); cyc();
        clr();
        reset = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cyc();
            #2;
            check("rpost_wben", MulWbEn, 0);
        end

        cyc(); cyc();
        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
        $finish;
    end

endmodule
